// File: rtl/enemy_ammo_pkg.sv
// Shared constants and slot types for the enemy projectile pool.
package enemy_ammo_pkg;

  localparam int unsigned NUM_SLOTS = 4;
  localparam int unsigned AMMO_W    = 8;
  localparam int unsigned AMMO_H    = 8;
  localparam int unsigned SCREEN_H  = 480;

  localparam int unsigned SLOT_IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int unsigned ROM_AW  = $clog2(AMMO_W * AMMO_H);
  localparam int unsigned COL_W   = $clog2(AMMO_W);
  localparam int unsigned ROW_W   = $clog2(AMMO_H);

  typedef logic [SLOT_IW-1:0] slot_idx_t;

  typedef struct packed {
    logic       valid;
    logic [9:0] x;
    logic [9:0] y;
  } ammo_slot_t;

endpackage

// File: rtl/enemy_ammo_controller_priority_enc.sv
// Generic lowest-set-bit encoder: reports whether any request bit is set and the lowest such index.
module ammo_priority_enc #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  output logic          found,
  output logic [IW-1:0] index
);

  always_comb begin
    found = 1'b0;
    index = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i] && !found) begin
        found = 1'b1;
        index = IW'(i);
      end
    end
  end

endmodule

// File: rtl/enemy_ammo_controller.sv
// Enemy projectile pool: fire allocation, per-frame motion/retirement and pixel-to-sprite-address lookup.
// Optional fire cooldown enabled by defining ENEMY_AMMO_COOLDOWN_EN.
module enemy_ammo_controller
  import enemy_ammo_pkg::*;
#(
  parameter int unsigned SPEED    = 3,
  parameter int unsigned COOLDOWN = 10
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 frame_tick,
  input  logic                 fire_req,
  input  logic [9:0]           fire_x,
  input  logic [9:0]           fire_y,
  output logic                 fire_ack,
  input  logic [NUM_SLOTS-1:0] hit_clear,
  input  logic [9:0]           DrawX,
  input  logic [9:0]           DrawY,
  output logic                 ammo_on,
  output logic [ROM_AW-1:0]    rom_addr,
  output logic [NUM_SLOTS-1:0] active_mask
);

  if (COOLDOWN > 255) begin : g_cooldown_range
    $error("COOLDOWN must fit the 8-bit frame counter");
  end

  ammo_slot_t           slots [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] valid_vec;
  logic [NUM_SLOTS-1:0] cover_vec;
  logic [10:0]          ysum  [NUM_SLOTS];
  logic [10:0]          dx    [NUM_SLOTS];
  logic [10:0]          dy    [NUM_SLOTS];

  logic                 free_found;
  slot_idx_t            free_idx;
  logic                 win_found;
  slot_idx_t            win_idx;
  logic                 cooldown_ok;
  logic [ROM_AW-1:0]    rom_next;

  // Offsets are 11-bit so the upper bound check never wraps near the screen edge.
  always_comb begin
    valid_vec = '0;
    cover_vec = '0;
    ysum      = '{default: '0};
    dx        = '{default: '0};
    dy        = '{default: '0};
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      valid_vec[i] = slots[i].valid;
      ysum[i]      = {1'b0, slots[i].y} + 11'(SPEED);
      dx[i]        = {1'b0, DrawX} - {1'b0, slots[i].x};
      dy[i]        = {1'b0, DrawY} - {1'b0, slots[i].y};
      cover_vec[i] = slots[i].valid
                  && (DrawX >= slots[i].x) && (dx[i] < 11'(AMMO_W))
                  && (DrawY >= slots[i].y) && (dy[i] < 11'(AMMO_H));
    end
  end

  assign active_mask = valid_vec;

  ammo_priority_enc #(
    .N  (NUM_SLOTS),
    .IW (SLOT_IW)
  ) u_free_enc (
    .req   (~valid_vec),
    .found (free_found),
    .index (free_idx)
  );

  ammo_priority_enc #(
    .N  (NUM_SLOTS),
    .IW (SLOT_IW)
  ) u_pixel_enc (
    .req   (cover_vec),
    .found (win_found),
    .index (win_idx)
  );

`ifdef ENEMY_AMMO_COOLDOWN_EN
  logic [7:0] cd_cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cd_cnt <= '0;
    end else if (fire_ack) begin
      cd_cnt <= 8'(COOLDOWN);
    end else if (frame_tick && (cd_cnt != '0)) begin
      cd_cnt <= cd_cnt - 8'd1;
    end
  end

  assign cooldown_ok = (cd_cnt == '0);
`else
  assign cooldown_ok = 1'b1;
`endif

  assign fire_ack = fire_req && free_found && cooldown_ok;

  // A freshly loaded slot takes fire_y as-is, so a same-edge frame_tick never moves it.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        slots[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        if (fire_ack && (free_idx == slot_idx_t'(i))) begin
          slots[i].valid <= 1'b1;
          slots[i].x     <= fire_x;
          slots[i].y     <= fire_y;
        end else if (hit_clear[i]) begin
          slots[i].valid <= 1'b0;
        end else if (frame_tick && slots[i].valid) begin
          slots[i].y <= ysum[i][9:0];
          if (ysum[i] >= 11'(SCREEN_H)) begin
            slots[i].valid <= 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    rom_next = '0;
    if (win_found) begin
      rom_next = {dy[win_idx][ROW_W-1:0], dx[win_idx][COL_W-1:0]};
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ammo_on  <= 1'b0;
      rom_addr <= '0;
    end else begin
      ammo_on  <= win_found;
      rom_addr <= rom_next;
    end
  end

endmodule

// File: tb/tb_enemy_ammo_controller.sv
// Self-checking bench for enemy_ammo_controller: behavioural pool model plus directed literal checks.
module tb_enemy_ammo_controller;

  localparam int SPD = 3;
  localparam int CD  = 2;
`ifdef ENEMY_AMMO_COOLDOWN_EN
  localparam bit COOL_ON = 1'b1;
`else
  localparam bit COOL_ON = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       fire_req = 1'b0;
  logic [9:0] fire_x = '0;
  logic [9:0] fire_y = '0;
  logic       fire_ack;
  logic [3:0] hit_clear = '0;
  logic [9:0] DrawX = '0;
  logic [9:0] DrawY = '0;
  logic       ammo_on;
  logic [5:0] rom_addr;
  logic [3:0] active_mask;

  int checks = 0;
  int failures = 0;

  enemy_ammo_controller #(
    .SPEED    (SPD),
    .COOLDOWN (CD)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_tick  (frame_tick),
    .fire_req    (fire_req),
    .fire_x      (fire_x),
    .fire_y      (fire_y),
    .fire_ack    (fire_ack),
    .hit_clear   (hit_clear),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .ammo_on     (ammo_on),
    .rom_addr    (rom_addr),
    .active_mask (active_mask)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each slot is (valid, x, y) as plain integers.
  int  mv [4];
  int  mx [4];
  int  my [4];
  int  cnt = 0;
  int  e_on = 0;
  int  e_addr = 0;
  bit  model_ok = 1'b0;

  function automatic int model_ack();
    int any_free = 0;
    for (int i = 0; i < 4; i++) if (mv[i] == 0) any_free = 1;
    return (fire_req == 1'b1 && any_free == 1 && (!COOL_ON || cnt == 0)) ? 1 : 0;
  endfunction

  function automatic int model_mask();
    int m = 0;
    for (int i = 0; i < 4; i++) if (mv[i] != 0) m += (1 << i);
    return m;
  endfunction

  initial begin
    for (int i = 0; i < 4; i++) begin
      mv[i] = 0; mx[i] = 0; my[i] = 0;
    end
    forever begin
      @(negedge Clk);
      #2;
      if (model_ok) begin
        chk("fire_ack", int'(fire_ack), model_ack());
        chk("ammo_on", int'(ammo_on), e_on);
        chk("rom_addr", int'(rom_addr), e_addr);
        chk("active_mask", int'(active_mask), model_mask());
      end
      @(posedge Clk);
      if (Reset) begin
        for (int i = 0; i < 4; i++) begin
          mv[i] = 0; mx[i] = 0; my[i] = 0;
        end
        cnt = 0; e_on = 0; e_addr = 0; model_ok = 1'b1;
      end else begin
        int ack;
        int fr;
        int px;
        int py;
        ack = model_ack();
        fr = -1;
        if (ack == 1) for (int i = 3; i >= 0; i--) if (mv[i] == 0) fr = i;
        px = int'(DrawX);
        py = int'(DrawY);
        e_on = 0; e_addr = 0;
        for (int i = 3; i >= 0; i--) begin
          if (mv[i] != 0 && px >= mx[i] && px < mx[i] + 8 && py >= my[i] && py < my[i] + 8) begin
            e_on = 1;
            e_addr = (py - my[i]) * 8 + (px - mx[i]);
          end
        end
        for (int i = 0; i < 4; i++) begin
          if (i == fr) begin
            mv[i] = 1; mx[i] = int'(fire_x); my[i] = int'(fire_y);
          end else if (hit_clear[i]) begin
            mv[i] = 0;
          end else if (frame_tick && mv[i] != 0) begin
            if (my[i] + SPD >= 480) mv[i] = 0;
            my[i] = (my[i] + SPD) % 1024;
          end
        end
        if (COOL_ON) begin
          if (ack == 1) cnt = CD;
          else if (frame_tick && cnt > 0) cnt--;
        end
      end
    end
  end

  task automatic cyc(input bit r, input bit fr, input int fx, input int fy,
                     input bit tk, input logic [3:0] hc, input int px, input int py);
    @(negedge Clk);
    Reset = r; fire_req = fr; fire_x = 10'(fx); fire_y = 10'(fy);
    frame_tick = tk; hit_clear = hc; DrawX = 10'(px); DrawY = 10'(py);
    #1;
  endtask

  task automatic settle();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(1, 0, 0, 0, 0, 4'b0000, 0, 0);
    cyc(1, 0, 0, 0, 0, 4'b0000, 0, 0);
    settle();
    chk("reset_mask", int'(active_mask), 0);
    chk("reset_on", int'(ammo_on), 0);
    chk("reset_addr", int'(rom_addr), 0);

`ifdef ENEMY_AMMO_COOLDOWN_EN
    cyc(0, 1, 10, 10, 0, 4'b0000, 0, 0);
    chk("cd_first_ack", int'(fire_ack), 1);
    cyc(0, 1, 20, 10, 0, 4'b0000, 0, 0);
    chk("cd_blocked0", int'(fire_ack), 0);
    cyc(0, 0, 0, 0, 1, 4'b0000, 0, 0);
    cyc(0, 1, 20, 10, 0, 4'b0000, 0, 0);
    chk("cd_blocked1", int'(fire_ack), 0);
    cyc(0, 0, 0, 0, 1, 4'b0000, 0, 0);
    cyc(0, 1, 20, 10, 0, 4'b0000, 0, 0);
    chk("cd_released", int'(fire_ack), 1);
    cyc(1, 0, 0, 0, 0, 4'b0000, 0, 0);
`endif

    cyc(0, 1, 100, 50, 0, 4'b0000, 0, 0);
    chk("fire0_ack", int'(fire_ack), 1);
    settle();
    chk("fire0_mask", int'(active_mask), 1);

    cyc(0, 0, 0, 0, 0, 4'b0000, 103, 52);
    settle();
    chk("pix_on", int'(ammo_on), 1);
    chk("pix_addr", int'(rom_addr), 19);
    cyc(0, 0, 0, 0, 0, 4'b0000, 108, 52);
    settle();
    chk("pix_edge_on", int'(ammo_on), 0);
    chk("pix_edge_addr", int'(rom_addr), 0);

`ifndef ENEMY_AMMO_COOLDOWN_EN
    cyc(0, 1, 200, 100, 0, 4'b0000, 0, 0);
    chk("fire1_ack", int'(fire_ack), 1);
    cyc(0, 1, 300, 477, 0, 4'b0000, 0, 0);
    chk("fire2_ack", int'(fire_ack), 1);
    cyc(0, 1, 400, 10, 0, 4'b0000, 0, 0);
    chk("fire3_ack", int'(fire_ack), 1);
    settle();
    chk("full_mask", int'(active_mask), 15);
    cyc(0, 1, 5, 5, 0, 4'b0000, 0, 0);
    chk("full_nack", int'(fire_ack), 0);
    settle();
    chk("full_mask_hold", int'(active_mask), 15);

    // slot2 477->480 retires; slot1 100->103
    cyc(0, 0, 0, 0, 1, 4'b0000, 0, 0);
    settle();
    chk("retire_mask", int'(active_mask), 4'b1011);
    cyc(0, 0, 0, 0, 0, 4'b0000, 201, 110);
    settle();
    chk("moved_addr", int'(rom_addr), 57);
    cyc(0, 0, 0, 0, 0, 4'b0000, 201, 102);
    settle();
    chk("moved_above_on", int'(ammo_on), 0);

    cyc(0, 1, 198, 101, 0, 4'b0000, 202, 105);
    chk("refill_ack", int'(fire_ack), 1);
    cyc(0, 0, 0, 0, 0, 4'b0000, 202, 105);
    settle();
    chk("overlap_lowest_addr", int'(rom_addr), 18);

    cyc(0, 1, 7, 7, 1, 4'b0010, 0, 0);
    chk("hit_same_cycle_nack", int'(fire_ack), 0);
    settle();
    chk("hit_mask", int'(active_mask), 4'b1101);
    cyc(0, 1, 50, 60, 0, 4'b0000, 0, 0);
    chk("hit_next_ack", int'(fire_ack), 1);
    cyc(0, 0, 0, 0, 0, 4'b0000, 50, 60);
    settle();
    chk("slot1_reload_on", int'(ammo_on), 1);

    cyc(0, 0, 0, 0, 0, 4'b1000, 0, 0);
    settle();
    chk("hit3_mask", int'(active_mask), 4'b0111);
    cyc(0, 1, 636, 200, 1, 4'b0000, 0, 0);
    chk("fire_tick_ack", int'(fire_ack), 1);
    cyc(0, 0, 0, 0, 0, 4'b0000, 639, 207);
    settle();
    chk("unmoved_clip_addr", int'(rom_addr), 59);
`endif

    for (int k = 0; k < 170; k++) begin
      cyc(0, (k % 40) == 3, 60 * (k % 9), 300 + k, 1, 4'b0000, 100 + (k % 8), 56 + 3 * k + (k % 8));
    end
    for (int k = 0; k < 170; k++) begin
      cyc(0, 0, 0, 0, 1, 4'b0000, 0, 0);
    end
    settle();
    chk("all_retired_mask", int'(active_mask), 0);

    cyc(0, 1, 30, 30, 0, 4'b0000, 0, 0);
    cyc(1, 0, 0, 0, 1, 4'b0000, 31, 31);
    settle();
    chk("midframe_reset_mask", int'(active_mask), 0);
    chk("midframe_reset_on", int'(ammo_on), 0);
    cyc(0, 0, 0, 0, 0, 4'b0000, 31, 31);
    cyc(0, 0, 0, 0, 0, 4'b0000, 0, 0);
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/enemy_ammo_controller.md
Name: enemy_ammo_controller

Overview:
- Manages a fixed pool of enemy projectile slots: accepts fire requests from enemy logic, advances projectiles once per frame, and retires them on screen exit or hit.
- During scanout, it resolves which projectile, if any, covers the current pixel.
- It then emits the sprite ROM address that drives the enemy ammo sprite ROM and colour palette lookup.
- Sits between the enemy FSMs, the collision unit and the colour mapper.

Parameters:
- NUM_SLOTS, 4, number of concurrent projectiles.
- AMMO_W, 8, sprite width in pixels (power of 2).
- AMMO_H, 8, sprite height in pixels (power of 2).
- SPEED, 3, pixels moved downward per frame.
- SCREEN_H, 480, visible lines; a projectile with y >= SCREEN_H is retired.
- COOLDOWN, 10, frames between accepted fires (used only with the optional feature).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  single-cycle pulse at start of vertical blank.
- fire_req  in  1  enemy requests a shot.
- fire_x  in  10  spawn x (top-left).
- fire_y  in  10  spawn y (top-left).
- fire_ack  out  1  combinational; request accepted this cycle.
- hit_clear  in  NUM_SLOTS  per-slot retire from the collision unit.
- DrawX  in  10  current pixel x.
- DrawY  in  10  current pixel y.
- ammo_on  out  1  registered; pixel covered by a projectile.
- rom_addr  out  $clog2(AMMO_W*AMMO_H)  registered sprite address, row*AMMO_W+col.
- active_mask  out  NUM_SLOTS  registered slot valid bits.

Behaviour:
- Reset (synchronous, high):
  - All slot valid, x and y cleared.
  - ammo_on=0, rom_addr=0, active_mask=0.
  - Cooldown counter = 0.
  - Reset mid-frame discards all projectiles immediately on that edge.
- Slot state: valid, x[9:0], y[9:0]. active_mask mirrors the valid bits.
- Fire:
  - fire_ack = fire_req & (any slot with registered valid=0) & cooldown_ok.
  - On an ack edge, the lowest-index free slot loads fire_x/fire_y and sets valid.
  - Pool full: fire_ack=0; the request is dropped, not queued.
- Move:
  - On a frame_tick edge, every valid slot gets y <= y+SPEED using 11-bit arithmetic (no wrap).
  - If y+SPEED >= SCREEN_H, valid <= 0.
- Priority on the same slot, same edge: hit_clear > move.
  - A slot cleared by hit_clear is not free for a fire in that same cycle, because free is computed from the registered valid bits.
- Simultaneous fire and frame_tick: existing slots move; the newly loaded slot holds fire_y unmoved.
- Pixel path (1-cycle latency):
  - Slot i covers the pixel if valid, x <= DrawX < x+AMMO_W, and y <= DrawY < y+AMMO_H, compared in 11-bit.
  - The lowest covering index wins.
  - Next edge: ammo_on <= any covering slot; rom_addr <= (DrawY-y)*AMMO_W + (DrawX-x) of the winning slot, else 0.
  - x+AMMO_W beyond 639 is clipped naturally by the DrawX range.

Optional Feature:
- Macro: ENEMY_AMMO_COOLDOWN_EN.
- Defined:
  - An 8-bit frame counter is loaded with COOLDOWN on each accepted fire.
  - The counter decrements on frame_tick down to 0.
  - cooldown_ok = (counter==0).
- Undefined: cooldown_ok tied to 1, the counter is not instantiated, and COOLDOWN is ignored.

Decomposition:
- enemy_ammo_pkg: NUM_SLOTS, AMMO_W, AMMO_H, SCREEN_H constants; typedef struct ammo_slot_t {valid, x, y}; typedef for slot index.
- Sub-module ammo_priority_enc:
  - Generic lowest-set-bit encoder outputting {found, index}.
  - Instantiated twice: free-slot selection on ~valid, and pixel-winner selection on the coverage vector.

Test Plan:
- Reset, then fire_req with fire_x=100, fire_y=50 → fire_ack=1; next cycle active_mask=0001, slot0=(100,50).
- Four accepted fires, then a fifth fire_req → fifth fire_ack=0; active_mask=1111 unchanged.
- Slot0 at y=475, SPEED=3, frame_tick → slot0 valid=0 (478 is not >= 480, so use y=477 → 480, retired); a slot at y=100 moves to 103.
- hit_clear=0010 with frame_tick and fire_req in the same cycle, pool full → slot1 cleared, no fire accepted; fire accepted the following cycle into slot1.
- Slot0 at (100,50), DrawX=103, DrawY=52 → one cycle later ammo_on=1, rom_addr=19; DrawX=108 → ammo_on=0, rom_addr=0.
- With ENEMY_AMMO_COOLDOWN_EN, COOLDOWN=2: fire accepted, then fire_ack=0 until two frame_ticks have passed; without the macro, back-to-back fires are both acked.
